adpll_sweep_ctrl: RTL and testbench

Sequencer for characterising the ring-oscillator ADPLL. It steps the phase-accumulator tuning word across a programmed range and resets the ADPLL at each point. It then waits for lock, judged by the signed phase error staying within a threshold, and reports per-point lock result and acquisition time. It sits in the fpga_clk_i domain between the switch/start logic, the reference PhaseAccum (drives its k_val_i) and RingADPLL (drives its reset/enable, reads its error_o).

---
 rtl/adpll_sweep_ctrl_if.sv | 33 +++
 rtl/adpll_sweep_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_adpll_sweep_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adpll_sweep_ctrl_if.sv
// Interface bundle between the sweep sequencer and its start logic / ADPLL / PhaseAccum.
// master = the side driving start/abort/ref/error, slave = adpll_sweep_ctrl.
interface adpll_sweep_ctrl_if #(
    parameter int WIDTH = 12
);
    logic             start_i;
    logic             abort_i;
    logic             ref_clk_i;
    logic [7:0]       error_i;
    logic [WIDTH-1:0] k_val_o;
    logic             pll_reset_o;
    logic             pll_enable_o;
    logic             busy_o;
    logic             done_o;
    logic             result_valid_o;
    logic [WIDTH-1:0] result_k_o;
    logic             result_locked_o;
    logic [15:0]      result_edges_o;
    logic [WIDTH-1:0] lock_total_o;
    logic [7:0]       peak_err_o;

    modport master (
        output start_i, abort_i, ref_clk_i, error_i,
        input  k_val_o, pll_reset_o, pll_enable_o, busy_o, done_o, result_valid_o,
        input  result_k_o, result_locked_o, result_edges_o, lock_total_o, peak_err_o
    );

    modport slave (
        input  start_i, abort_i, ref_clk_i, error_i,
        output k_val_o, pll_reset_o, pll_enable_o, busy_o, done_o, result_valid_o,
        output result_k_o, result_locked_o, result_edges_o, lock_total_o, peak_err_o
    );
endinterface

// File: rtl/adpll_sweep_ctrl.sv
// ADPLL tuning-word sweep sequencer: per-point reset, settle, lock measurement and report.
// Peak |error| tracking is built only when ADPLL_SWEEP_PEAK_ERR_EN is defined.
//
// state     | meaning
// S_IDLE    | ADPLL held in reset, waiting for start_i
// S_RST     | ADPLL reset pulse with new tuning word, RST_CYCLES clocks
// S_SETTLE  | ignore SETTLE_EDGES reference edges
// S_MEASURE | sample error per ref edge, count in-threshold run and edges
// S_REPORT  | one-clock result strobe, pick next tuning word
// S_DONE    | one-clock end-of-sweep strobe
module adpll_sweep_ctrl #(
    parameter int WIDTH         = 12,
    parameter int K_START       = 100,
    parameter int K_STEP        = 4,
    parameter int K_STOP        = 200,
    parameter int RST_CYCLES    = 8,
    parameter int SETTLE_EDGES  = 64,
    parameter int LOCK_THRESH   = 4,
    parameter int LOCK_COUNT    = 16,
    parameter int TIMEOUT_EDGES = 1024
) (
    input logic               fpga_clk_i,
    input logic               rst_pbn_i,
    adpll_sweep_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_SETTLE, S_MEASURE, S_REPORT, S_DONE
    } state_t;

    localparam logic [15:0]      RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_EDGES - 1);
    localparam logic [15:0]      LOCK_N      = 16'(LOCK_COUNT);
    localparam logic [15:0]      TIMEOUT_N   = 16'(TIMEOUT_EDGES);
    localparam logic [7:0]       THRESH      = 8'(LOCK_THRESH);
    localparam logic [WIDTH-1:0] K_START_W   = WIDTH'(K_START);
    localparam logic [WIDTH:0]   K_STEP_W    = (WIDTH+1)'(K_STEP);
    localparam logic [WIDTH:0]   K_STOP_W    = (WIDTH+1)'(K_STOP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] lock_total_q, lock_total_d;
    logic [WIDTH-1:0] res_k_q, res_k_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0]      run_q, run_d;
    logic [15:0]      edges_q, edges_d;
    logic [15:0]      res_edges_q, res_edges_d;
    logic             res_locked_q, res_locked_d;
    logic             ref_q;
    logic             ref_edge;
    logic [7:0]       mag;
    logic [15:0]      run_inc, edges_inc;
    logic [WIDTH:0]   k_next;

    assign ref_edge = bus.ref_clk_i & ~ref_q;

    // -128 has no positive twin in 8 bits, so it saturates to 127
    always_comb begin
        if (bus.error_i == 8'h80)
            mag = 8'd127;
        else if (bus.error_i[7])
            mag = ~bus.error_i + 8'd1;
        else
            mag = bus.error_i;
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        lock_total_d = lock_total_q;
        res_k_d      = res_k_q;
        res_locked_d = res_locked_q;
        res_edges_d  = res_edges_q;
        cnt_d        = cnt_q;
        run_d        = run_q;
        edges_d      = edges_q;
        run_inc      = (mag <= THRESH) ? run_q + 16'd1 : 16'd0;
        edges_inc    = (edges_q == 16'hFFFF) ? edges_q : edges_q + 16'd1;
        k_next       = {1'b0, k_q} + K_STEP_W;

        if (state_q != S_IDLE && bus.abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_d      = S_RST;
                        k_d          = K_START_W;
                        lock_total_d = '0;
                        cnt_d        = RST_LAST;
                    end
                end
                S_RST: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_LAST;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (ref_edge) begin
                        if (cnt_q == 16'd0) begin
                            state_d = S_MEASURE;
                            run_d   = 16'd0;
                            edges_d = 16'd0;
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (ref_edge) begin
                        run_d   = run_inc;
                        edges_d = edges_inc;
                        // lock takes priority when lock and timeout land on the same edge
                        if (run_inc >= LOCK_N || edges_inc >= TIMEOUT_N) begin
                            state_d      = S_REPORT;
                            res_k_d      = k_q;
                            res_locked_d = (run_inc >= LOCK_N);
                            res_edges_d  = edges_inc;
                            if (run_inc >= LOCK_N && lock_total_q != '1)
                                lock_total_d = lock_total_q + WIDTH'(1);
                        end
                    end
                end
                S_REPORT: begin
                    if (k_next > K_STOP_W || k_next[WIDTH]) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RST;
                        k_d     = k_next[WIDTH-1:0];
                        cnt_d   = RST_LAST;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            state_q      <= S_IDLE;
            k_q          <= K_START_W;
            lock_total_q <= '0;
            res_k_q      <= '0;
            res_locked_q <= 1'b0;
            res_edges_q  <= 16'd0;
            cnt_q        <= 16'd0;
            run_q        <= 16'd0;
            edges_q      <= 16'd0;
            ref_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            lock_total_q <= lock_total_d;
            res_k_q      <= res_k_d;
            res_locked_q <= res_locked_d;
            res_edges_q  <= res_edges_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            edges_q      <= edges_d;
            ref_q        <= bus.ref_clk_i;
        end
    end

`ifdef ADPLL_SWEEP_PEAK_ERR_EN
    logic [7:0] peak_q, res_peak_q, peak_max;
    logic       measure_enter, report_load;

    assign peak_max      = (mag > peak_q) ? mag : peak_q;
    assign measure_enter = (state_q == S_SETTLE) && (state_d == S_MEASURE);
    assign report_load   = (state_q == S_MEASURE) && (state_d == S_REPORT);

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            peak_q     <= 8'd0;
            res_peak_q <= 8'd0;
        end else begin
            if (measure_enter)
                peak_q <= 8'd0;
            else if (state_q == S_MEASURE && ref_edge)
                peak_q <= peak_max;
            if (report_load)
                res_peak_q <= peak_max;
        end
    end

    assign bus.peak_err_o = res_peak_q;
`else
    assign bus.peak_err_o = 8'd0;
`endif

    assign bus.k_val_o         = k_q;
    assign bus.pll_reset_o     = (state_q == S_IDLE) || (state_q == S_RST);
    assign bus.pll_enable_o    = (state_q != S_IDLE);
    assign bus.busy_o          = (state_q != S_IDLE);
    assign bus.done_o          = (state_q == S_DONE);
    assign bus.result_valid_o  = (state_q == S_REPORT);
    assign bus.result_k_o      = res_k_q;
    assign bus.result_locked_o = res_locked_q;
    assign bus.result_edges_o  = res_edges_q;
    assign bus.lock_total_o    = lock_total_q;

endmodule

// File: tb/tb_adpll_sweep_ctrl.sv
// Bench for adpll_sweep_ctrl: table-driven sweeps, hand sequences for abort/reset,
// and randomized error streams checked against a per-point lock model.
`timescale 1ns/1ps
module tb_adpll_sweep_ctrl;
    localparam int W       = 12;
    localparam int SETTLE  = 64;
    localparam int TIMEOUT = 1024;
    localparam int LOCKN   = 16;
    localparam int THR     = 4;
`ifdef ADPLL_SWEEP_PEAK_ERR_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    typedef struct {
        bit sel;
        int kind;
        bit locked;
        int edges;
        int peak;
        int total;
    } vec_t;

    typedef struct {
        int k;
        bit locked;
        int edges;
        int peak;
    } res_t;

    logic fpga_clk = 1'b0;
    logic rst_pbn  = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   rv_a = 0, rv_b = 0, done_a = 0, done_b = 0;
    res_t res_a[$];
    res_t res_b[$];
    int   rnd_s[1100];
    vec_t tbl[7];

    adpll_sweep_ctrl_if #(.WIDTH(W)) ifa ();
    adpll_sweep_ctrl_if #(.WIDTH(W)) ifb ();

    adpll_sweep_ctrl #(
        .WIDTH(W), .K_START(100), .K_STEP(4), .K_STOP(108), .RST_CYCLES(8),
        .SETTLE_EDGES(SETTLE), .LOCK_THRESH(THR), .LOCK_COUNT(LOCKN), .TIMEOUT_EDGES(TIMEOUT)
    ) dut_a (
        .fpga_clk_i(fpga_clk), .rst_pbn_i(rst_pbn), .bus(ifa)
    );

    adpll_sweep_ctrl #(
        .WIDTH(W), .K_START(4090), .K_STEP(8), .K_STOP(4095), .RST_CYCLES(8),
        .SETTLE_EDGES(SETTLE), .LOCK_THRESH(THR), .LOCK_COUNT(LOCKN), .TIMEOUT_EDGES(TIMEOUT)
    ) dut_b (
        .fpga_clk_i(fpga_clk), .rst_pbn_i(rst_pbn), .bus(ifb)
    );

    always #5 fpga_clk = ~fpga_clk;

    always @(negedge fpga_clk) begin
        if (ifa.result_valid_o === 1'b1) begin
            rv_a++;
            res_a.push_back('{int'(ifa.result_k_o), ifa.result_locked_o,
                              int'(ifa.result_edges_o), int'(ifa.peak_err_o)});
        end
        if (ifb.result_valid_o === 1'b1) begin
            rv_b++;
            res_b.push_back('{int'(ifb.result_k_o), ifb.result_locked_o,
                              int'(ifb.result_edges_o), int'(ifb.peak_err_o)});
        end
        if (ifa.done_o === 1'b1) done_a++;
        if (ifb.done_o === 1'b1) done_b++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge fpga_clk);
        #1;
    endtask

    // one reference period: high for one clock, low for one clock, error held throughout
    task automatic tick(input int e);
        ifa.error_i = 8'(e);   ifb.error_i = 8'(e);
        ifa.ref_clk_i = 1'b1;  ifb.ref_clk_i = 1'b1;
        @(posedge fpga_clk); #1;
        ifa.ref_clk_i = 1'b0;  ifb.ref_clk_i = 1'b0;
        @(posedge fpga_clk); #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) ifb.start_i = 1'b1;
        else     ifa.start_i = 1'b1;
        @(posedge fpga_clk); #1;
        ifa.start_i = 1'b0;
        ifb.start_i = 1'b0;
    endtask

    function automatic int pat(input int kind, input int i);
        case (kind)
            0:       return 0;
            1:       return 10;
            2:       return (i % 2 == 0) ? -4 : 4;
            3:       return (i < 15) ? -3 : ((i == 15) ? 5 : 4);
            4:       return -128;
            5:       return (i == 0) ? 3 : ((i == 1) ? -7 : ((i == 2) ? 2 : 0));
            default: return rnd_s[i];
        endcase
    endfunction

    // expected outcome of one measure window given the sample stream
    task automatic model(input int kind, output bit locked, output int edges, output int peak);
        int run;
        int m;
        run = 0; locked = 1'b0; edges = TIMEOUT; peak = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            m = pat(kind, i);
            if (m == -128) m = 127;
            else if (m < 0) m = -m;
            if (m > peak) peak = m;
            run = (m <= THR) ? run + 1 : 0;
            if (run == LOCKN) begin
                locked = 1'b1;
                edges  = i + 1;
                break;
            end
        end
    endtask

    task automatic fill_random();
        int mode;
        mode = int'($urandom_range(0, 2));
        for (int i = 0; i < 1100; i++) begin
            case (mode)
                0:       rnd_s[i] = int'($urandom_range(0, 10)) - 5;
                1:       rnd_s[i] = int'($urandom_range(0, 18)) - 9;
                default: rnd_s[i] = ($urandom_range(0, 19) == 0) ? -128 : 0;
            endcase
        end
    endtask

    task automatic run_point(input bit sel, input int kind);
        int rv0, cur;
        rv0 = sel ? rv_b : rv_a;
        idle(10);
        repeat (SETTLE) tick(100);
        cur = rv0;
        for (int i = 0; i < 1100 && cur == rv0; i++) begin
            tick(pat(kind, i));
            cur = sel ? rv_b : rv_a;
        end
        chk("point_reported", 32'(cur - rv0), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_k_val"},        ifa.k_val_o, 100);
        chk({tag, "_pll_reset"},    ifa.pll_reset_o, 1);
        chk({tag, "_pll_enable"},   ifa.pll_enable_o, 0);
        chk({tag, "_busy"},         ifa.busy_o, 0);
        chk({tag, "_done"},         ifa.done_o, 0);
        chk({tag, "_result_valid"}, ifa.result_valid_o, 0);
        chk({tag, "_result_k"},     ifa.result_k_o, 0);
        chk({tag, "_result_lock"},  ifa.result_locked_o, 0);
        chk({tag, "_result_edges"}, ifa.result_edges_o, 0);
        chk({tag, "_lock_total"},   ifa.lock_total_o, 0);
        chk({tag, "_peak_err"},     ifa.peak_err_o, 0);
    endtask

    task automatic sweep(input vec_t v, input bit use_model);
        int   npts, kstart, kstep, d0, tot, e_edges, e_peak;
        bit   e_locked;
        res_t r;
        npts   = v.sel ? 1 : 3;
        kstart = v.sel ? 4090 : 100;
        kstep  = v.sel ? 8 : 4;
        d0     = v.sel ? done_b : done_a;
        tot    = 0;
        pulse_start(v.sel);
        for (int p = 0; p < npts; p++) begin
            if (use_model) fill_random();
            run_point(v.sel, v.kind);
            if (use_model) begin
                model(v.kind, e_locked, e_edges, e_peak);
            end else begin
                e_locked = v.locked; e_edges = v.edges; e_peak = v.peak;
            end
            if (!PEAK_EN) e_peak = 0;
            tot += int'(e_locked);
            if ((v.sel ? res_b.size() : res_a.size()) > 0) begin
                r = v.sel ? res_b.pop_front() : res_a.pop_front();
                chk($sformatf("res_k_kind%0d_pt%0d", v.kind, p), r.k, kstart + p * kstep);
                chk($sformatf("res_locked_kind%0d_pt%0d", v.kind, p), r.locked, e_locked);
                chk($sformatf("res_edges_kind%0d_pt%0d", v.kind, p), r.edges, e_edges);
                chk($sformatf("res_peak_kind%0d_pt%0d", v.kind, p), r.peak, e_peak);
            end
        end
        idle(4);
        chk($sformatf("done_pulses_kind%0d", v.kind), 32'((v.sel ? done_b : done_a) - d0), 1);
        chk($sformatf("lock_total_kind%0d", v.kind),
            v.sel ? ifb.lock_total_o : ifa.lock_total_o, use_model ? tot : v.total);
        chk($sformatf("k_hold_kind%0d", v.kind),
            v.sel ? ifb.k_val_o : ifa.k_val_o, kstart + (npts - 1) * kstep);
        chk($sformatf("busy_after_done_kind%0d", v.kind), v.sel ? ifb.busy_o : ifa.busy_o, 0);
    endtask

    initial begin
        int   n, d0, r0;
        res_t r;

        //          sel kind locked edges peak total
        tbl[0] = '{1'b0, 0, 1'b1,   16,   0, 3};
        tbl[1] = '{1'b0, 1, 1'b0, 1024,  10, 0};
        tbl[2] = '{1'b0, 2, 1'b1,   16,   4, 3};
        tbl[3] = '{1'b0, 3, 1'b1,   32,   5, 3};
        tbl[4] = '{1'b0, 4, 1'b0, 1024, 127, 0};
        tbl[5] = '{1'b0, 5, 1'b1,   18,   7, 3};
        tbl[6] = '{1'b1, 0, 1'b1,   16,   0, 1};

        ifa.start_i = 1'b0; ifa.abort_i = 1'b0; ifa.ref_clk_i = 1'b0; ifa.error_i = 8'd0;
        ifb.start_i = 1'b0; ifb.abort_i = 1'b0; ifb.ref_clk_i = 1'b0; ifb.error_i = 8'd0;

        idle(3);
        check_reset_vals("por");
        rst_pbn = 1'b1;
        idle(2);

        for (int i = 0; i < 7; i++) sweep(tbl[i], 1'b0);

        // reset pulse length, then abort during the second point's settle
        d0 = done_a;
        r0 = rv_a;
        pulse_start(1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge fpga_clk);
            if (i == 0) begin
                chk("rst_k_val", ifa.k_val_o, 100);
                chk("rst_enable", ifa.pll_enable_o, 1);
            end
            if (ifa.pll_reset_o && ifa.busy_o) n++;
        end
        chk("rst_len", n, 8);
        run_point(1'b0, 0);
        if (res_a.size() > 0) begin
            r = res_a.pop_front();
            chk("abort_pt0_locked", r.locked, 1);
        end
        idle(10);
        repeat (5) tick(100);
        ifa.abort_i = 1'b1;
        @(posedge fpga_clk); #1;
        ifa.abort_i = 1'b0;
        @(negedge fpga_clk);
        chk("abort_busy", ifa.busy_o, 0);
        chk("abort_pll_reset", ifa.pll_reset_o, 1);
        chk("abort_pll_enable", ifa.pll_enable_o, 0);
        chk("abort_lock_total", ifa.lock_total_o, 1);
        idle(20);
        chk("abort_no_done", 32'(done_a - d0), 0);
        chk("abort_results", 32'(rv_a - r0), 1);

        // asynchronous reset while measuring
        pulse_start(1'b0);
        idle(10);
        repeat (SETTLE) tick(100);
        repeat (5) tick(10);
        @(negedge fpga_clk);
        rst_pbn = 1'b0;
        #1;
        check_reset_vals("midrst");
        idle(2);
        rst_pbn = 1'b1;
        idle(2);
        sweep(tbl[0], 1'b0);

        for (int i = 0; i < 3; i++) sweep('{1'b0, 6, 1'b0, 0, 0, 0}, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
